grid_access_arbiter: RTL
========================

Name: grid_access_arbiter

Overview:
- Shares the single-port 32x24 grid cell RAM (4-bit cell codes NULL/SNAKE/ROCK/SNACK) among three requesters: display reader, game-controller writer and game-controller reader.
- Contains a pipelined read-return path, a starvation guard and a full-grid clear sequencer used at game INIT.
- Out-of-field coordinates are treated as wall: reads return ROCK and writes are dropped.

Parameters:
- GRID_X, 32, grid columns (x range 0..GRID_X-1).
- GRID_Y, 24, grid rows (y range 0..GRID_Y-1).
- MAX_WAIT, 8, consecutive lost-arbitration cycles before a pending controller request takes priority over display.
- CELL_W, 4, cell code width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- disp_req  in  1  display read request; held until granted.
- disp_x  in  5  display cell column.
- disp_y  in  5  display cell row.
- disp_gnt  out  1  combinational grant, same cycle as accepted request.
- disp_valid  out  1  one-cycle pulse, disp_data valid.
- disp_data  out  4  read cell code.
- wr_req  in  1  controller write request; held until granted.
- wr_data  in  36  {x[15:0], y[15:0], func[3:0]}.
- wr_gnt  out  1  write grant (combinational).
- rd_req  in  1  controller read request; held until granted.
- rd_addr  in  32  {x[15:0], y[15:0]}.
- rd_gnt  out  1  read grant (combinational).
- rd_valid  out  1  one-cycle pulse, rd_data valid.
- rd_data  out  4  read cell code.
- clr_start  in  1  pulse: clear whole grid to NULL.
- clr_busy  out  1  clear in progress.
- ram_en, ram_we  out  1 each  RAM strobes (registered).
- ram_addr  out  10  y*GRID_X + x (registered).
- ram_wdata  out  4  write data (registered).
- ram_rdata  in  4  RAM data, valid the cycle after ram_en with ram_we=0.
- oob_cnt  out  8  saturating count of out-of-field accesses.

Behaviour:
- Reset state: FSM=RUN; all grants, valids, ram_en/ram_we, clr_busy, oob_cnt, wait counter and tag pipe are 0; data outputs and ram_addr/ram_wdata are 0.
- RUN state, at most one grant per cycle:
  - Default priority is disp > wr > rd.
  - If wait_cnt == MAX_WAIT and wr_req|rd_req, priority becomes wr > rd > disp for that cycle.
- Wait counter:
  - Increments (saturating at MAX_WAIT) in each cycle where wr_req|rd_req is pending and neither wr_gnt nor rd_gnt is issued.
  - Clears to 0 on any controller grant, or when no controller request is pending.
- RAM port drive:
  - Granted in-field access in cycle C: ram_en=1 in C+1, ram_we=1 only for writes, ram_addr=y*32+x, ram_wdata=func.
  - No grant: ram_en=0, ram_we=0.
- In-field test: x < GRID_X and y < GRID_Y, using the full 16-bit fields for controller ports.
- Out-of-field access:
  - Still granted and oob_cnt increments, saturating at 255.
  - Write: ram_en stays 0.
  - Read: no RAM access; returns 4'b0010 (ROCK) with the normal latency.
- Read return:
  - A 2-stage tag pipe {valid, src, oob} follows every granted read.
  - Read granted in C gives valid pulse in C+2 on the owning port. Data = ram_rdata, or ROCK if oob; data is registered, other port unchanged.
  - Reads are returned in grant order; no back-pressure.
- Clear sequence:
  - clr_start=1 in RUN: no grants that cycle; enter CLEAR next cycle with clr_busy=1.
  - CLEAR issues ram_en=ram_we=1, wdata=0 for addr 0,1,…,767, one per cycle (768 cycles).
  - After the last write, return to RUN and drop clr_busy.
  - During CLEAR: all gnt=0, requests stay pending, clr_start is ignored, wait counter frozen.
  - Reads granted before CLEAR still return normally in the first CLEAR cycles.
- Reset mid-operation: immediate return to reset state. In-flight reads are discarded (no valid pulse) and an unfinished clear is abandoned.

Test Plan:
- Idle read: disp_req, x=3, y=2, ram_rdata=4'h1 → disp_gnt same cycle; ram_addr=67, ram_en=1 next cycle; disp_valid, disp_data=1 two cycles after grant.
- Contention: wr_req and rd_req held with disp_req continuously high → display granted for 8 cycles, then wr_gnt on 9th; rd_gnt within the following 9 cycles; wait_cnt reset after each.
- Out of field: wr_data={16'd32,16'd5,4'h4} → wr_gnt, ram_en stays 0, oob_cnt=1. rd_addr={16'd0,16'd24} → rd_valid, rd_data=4'h2, no RAM access.
- Clear: clr_start with disp_req pending → no grant for 769 cycles; 768 writes addr 0..767 with wdata=0; clr_busy falls after addr 767; disp_gnt the next cycle.
- Ordering: disp read granted cycle C, ctl read granted C+1 → disp_valid at C+2, rd_valid at C+3, each with the correct data.
- Async reset asserted one cycle after a read grant and during a clear at addr 100 → outputs zero immediately, no valid pulse, FSM RUN, no further RAM writes.

Source files
------------

// File: rtl/grid_access_arbiter.sv
// grid_access_arbiter: shares the single-port 32x24 grid cell RAM between the
// display reader, the controller writer and the controller reader. Includes a
// starvation guard for controller requests, a two-stage read-return tag pipe
// and a full-grid clear sequencer. Out-of-field coordinates behave as ROCK walls.
module grid_access_arbiter #(
    parameter int GRID_X   = 32,
    parameter int GRID_Y   = 24,
    parameter int MAX_WAIT = 8,
    parameter int CELL_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [4:0]        disp_x,
    input  logic [4:0]        disp_y,
    output logic              disp_gnt,
    output logic              disp_valid,
    output logic [CELL_W-1:0] disp_data,
    input  logic              wr_req,
    input  logic [CELL_W+31:0] wr_data,
    output logic              wr_gnt,
    input  logic              rd_req,
    input  logic [31:0]       rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [CELL_W-1:0] rd_data,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              ram_en,
    output logic              ram_we,
    output logic [9:0]        ram_addr,
    output logic [CELL_W-1:0] ram_wdata,
    input  logic [CELL_W-1:0] ram_rdata,
    output logic [7:0]        oob_cnt
);

    localparam int          WAIT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
    localparam logic [9:0]  LAST_ADDR = 10'(GRID_X * GRID_Y - 1);
    localparam logic [CELL_W-1:0] ROCK = CELL_W'(2);

    typedef enum logic {RUN, CLEAR} state_t;

    state_t              state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                tag1_v, tag1_src, tag1_oob;
    logic                tag2_v, tag2_src, tag2_oob;
    logic [CELL_W-1:0]   disp_hold, rd_hold;

    logic                ctl_prio, any_gnt, in_field;
    logic [15:0]         sel_x, sel_y;
    logic [CELL_W-1:0]   sel_func;
    logic [9:0]          addr_n;

    // Grant selection: one grant per cycle, controller first once the guard trips
    always_comb begin
        disp_gnt = 1'b0;
        wr_gnt   = 1'b0;
        rd_gnt   = 1'b0;
        ctl_prio = (wait_cnt == WAIT_MAX) && (wr_req || rd_req);
        if (!rst && state == RUN && !clr_start) begin
            if (ctl_prio) begin
                if (wr_req)        wr_gnt   = 1'b1;
                else if (rd_req)   rd_gnt   = 1'b1;
                else if (disp_req) disp_gnt = 1'b1;
            end else begin
                if (disp_req)      disp_gnt = 1'b1;
                else if (wr_req)   wr_gnt   = 1'b1;
                else if (rd_req)   rd_gnt   = 1'b1;
            end
        end
        any_gnt = disp_gnt || wr_gnt || rd_gnt;
    end

    // Coordinates of the granted access and its linear RAM address
    always_comb begin
        sel_func = '0;
        if (wr_gnt) begin
            sel_x    = wr_data[CELL_W+31:CELL_W+16];
            sel_y    = wr_data[CELL_W+15:CELL_W];
            sel_func = wr_data[CELL_W-1:0];
        end else if (rd_gnt) begin
            sel_x = rd_addr[31:16];
            sel_y = rd_addr[15:0];
        end else begin
            sel_x = {11'b0, disp_x};
            sel_y = {11'b0, disp_y};
        end
        in_field = (sel_x < 16'(GRID_X)) && (sel_y < 16'(GRID_Y));
        addr_n   = sel_y[9:0] * 10'(GRID_X) + sel_x[9:0];
    end

    // Read return: the pulse and data come straight from the stage-2 tag and the
    // RAM output so they land two cycles after the grant; the last value is held
    always_comb begin
        disp_valid = tag2_v && !tag2_src;
        rd_valid   = tag2_v && tag2_src;
        disp_data  = disp_hold;
        rd_data    = rd_hold;
        if (disp_valid) disp_data = tag2_oob ? ROCK : ram_rdata;
        if (rd_valid)   rd_data   = tag2_oob ? ROCK : ram_rdata;
    end

    // FSM, RAM strobes, wait counter, tag pipe and out-of-field counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            tag1_v    <= 1'b0;
            tag1_src  <= 1'b0;
            tag1_oob  <= 1'b0;
            tag2_v    <= 1'b0;
            tag2_src  <= 1'b0;
            tag2_oob  <= 1'b0;
            disp_hold <= '0;
            rd_hold   <= '0;
            clr_busy  <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            oob_cnt   <= '0;
        end else begin
            // tag pipe keeps shifting in CLEAR so earlier reads still return
            tag1_v   <= any_gnt && !wr_gnt;
            tag1_src <= rd_gnt;
            tag1_oob <= !in_field;
            tag2_v   <= tag1_v;
            tag2_src <= tag1_src;
            tag2_oob <= tag1_oob;
            if (disp_valid) disp_hold <= disp_data;
            if (rd_valid)   rd_hold   <= rd_data;

            case (state)
                RUN: begin
                    if (wr_gnt || rd_gnt || !(wr_req || rd_req))
                        wait_cnt <= '0;
                    else if (wait_cnt != WAIT_MAX)
                        wait_cnt <= wait_cnt + 1'b1;

                    if (clr_start) begin
                        // the first clear write is issued on entry so the strobes
                        // line up with clr_busy for addresses 0..LAST_ADDR
                        state     <= CLEAR;
                        clr_busy  <= 1'b1;
                        ram_en    <= 1'b1;
                        ram_we    <= 1'b1;
                        ram_addr  <= '0;
                        ram_wdata <= '0;
                    end else begin
                        ram_en <= any_gnt && in_field;
                        ram_we <= wr_gnt && in_field;
                        if (any_gnt && in_field) ram_addr  <= addr_n;
                        if (wr_gnt && in_field)  ram_wdata <= sel_func;
                        if (any_gnt && !in_field && oob_cnt != 8'hFF)
                            oob_cnt <= oob_cnt + 1'b1;
                    end
                end
                CLEAR: begin
                    if (ram_addr == LAST_ADDR) begin
                        state    <= RUN;
                        clr_busy <= 1'b0;
                        ram_en   <= 1'b0;
                        ram_we   <= 1'b0;
                    end else begin
                        ram_addr <= ram_addr + 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule
